// File: rtl/mem_arbiter.sv
// Three-way arbiter (instruction fetch, data, DMA) in front of the address
// interpreter's single request port. It runs the ren/wen-ack 4-phase handshake
// downstream and aborts transactions that hang for TIMEOUT cycles.
module mem_arbiter #(
  parameter int NREQ     = 3,
  parameter int TIMEOUT  = 255,
  parameter int DMA_PRIO = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ack,
  output logic [31:0]          req_rdata,
  output logic [NREQ-1:0]      req_err,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_data_i,
  output logic                 m_ren,
  output logic                 m_wen,
  input  logic                 m_ack,
  input  logic [31:0]          m_data_o,
  output logic [1:0]           grant,
  output logic [7:0]           timeout_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DROP, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        grant_q, grant_d;
  logic              op_wr_q, op_wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              m_ren_q, m_ren_d;
  logic              m_wen_q, m_wen_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d;
  logic [NREQ-1:0]   req_err_q, req_err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        tocnt_q, tocnt_d;

  logic [NREQ-1:0]   requesting;
  logic [1:0]        win;
  logic [2:0]        rr_sum;
  logic [1:0]        rr_idx;

  assign requesting = req_ren | req_wen;

  // Winner select: DMA override first, else first requester at or after rr.
  // Walking k downwards lets the lowest rotation offset overwrite the rest.
  always_comb begin
    win    = 2'd3;
    rr_sum = 3'd0;
    rr_idx = 2'd0;
    if (DMA_PRIO != 0 && requesting[2]) begin
      win = 2'd2;
    end else begin
      for (int k = NREQ-1; k >= 0; k--) begin
        rr_sum = {1'b0, rr_q} + 3'(k);
        if (rr_sum >= 3'(NREQ)) rr_sum = rr_sum - 3'(NREQ);
        rr_idx = rr_sum[1:0];
        if (requesting[rr_idx]) win = rr_idx;
      end
    end
  end

  // Next-state and next-output computation for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_ren_d   = m_ren_q;
    m_wen_d   = m_wen_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    req_ack_d = req_ack_q;
    req_err_d = req_err_q;
    rdata_d   = rdata_q;
    tocnt_d   = tocnt_q;
    case (state_q)
      S_IDLE: begin
        // A stale m_ack here is deliberately ignored; only requests matter.
        if (|requesting) begin
          grant_d = win;
          addr_d  = req_addr[win*32 +: 32];
          wdata_d = req_wdata[win*32 +: 32];
          // ren has precedence when a requester raises both strobes
          op_wr_d = ~req_ren[win];
          m_ren_d = req_ren[win];
          m_wen_d = ~req_ren[win];
          rr_d    = (win == 2'd2) ? 2'd0 : win + 2'd1;
          cnt_d   = 8'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_ack) begin
          if (!op_wr_q) rdata_d = m_data_o;
          m_ren_d = 1'b0;
          m_wen_d = 1'b0;
          state_d = S_DROP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          m_ren_d = 1'b0;
          m_wen_d = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'd0;
          tocnt_d = (tocnt_q == 8'hFF) ? 8'hFF : tocnt_q + 8'd1;
          state_d = S_DROP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DROP: begin
        // wait for the interpreter to release ack before answering upstream
        if (!m_ack) begin
          req_ack_d = NREQ'(1) << grant_q;
          req_err_d = err_q ? (NREQ'(1) << grant_q) : '0;
          state_d   = S_RESP;
        end
      end
      default: begin
        if (!requesting[grant_q]) begin
          req_ack_d = '0;
          req_err_d = '0;
          err_d     = 1'b0;
          grant_d   = 2'd3;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset drops downstream strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= 2'd0;
      grant_q   <= 2'd3;
      op_wr_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      m_ren_q   <= 1'b0;
      m_wen_q   <= 1'b0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      req_ack_q <= '0;
      req_err_q <= '0;
      rdata_q   <= 32'd0;
      tocnt_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      m_ren_q   <= m_ren_d;
      m_wen_q   <= m_wen_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      req_ack_q <= req_ack_d;
      req_err_q <= req_err_d;
      rdata_q   <= rdata_d;
      tocnt_q   <= tocnt_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign req_err     = req_err_q;
  assign req_rdata   = rdata_q;
  assign m_addr      = addr_q;
  assign m_data_i    = wdata_q;
  assign m_ren       = m_ren_q;
  assign m_wen       = m_wen_q;
  assign grant       = grant_q;
  assign timeout_cnt = tocnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requesters and an interpreter stub are
// driven from one stimulus loop; a transaction-level model predicts each
// downstream issue and upstream response, and two negedge monitors compare.
module tb_mem_arbiter;
  localparam int TIMEOUT  = 8;
  localparam int DMA_PRIO = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_ren, req_wen, req_ack, req_err;
  logic [95:0] req_addr, req_wdata;
  logic [31:0] req_rdata, m_addr, m_data_i, m_data_o;
  logic        m_ren, m_wen, m_ack;
  logic [1:0]  grant;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NREQ(3), .TIMEOUT(TIMEOUT), .DMA_PRIO(DMA_PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err),
    .m_addr(m_addr), .m_data_i(m_data_i), .m_ren(m_ren), .m_wen(m_wen),
    .m_ack(m_ack), .m_data_o(m_data_o), .grant(grant), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [31:0] addr; logic [31:0] wdata; bit rd; int len; } iss_t;
  typedef struct { int idx; logic [31:0] rdata; bit err; int tocnt; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  // reference model state
  int          mdl_rr = 0;
  logic [31:0] mdl_rdata = 32'd0;
  int          mdl_tocnt = 0;
  // stub and requester state
  int          st_delay = 0;
  int          st_drop = 0;
  logic [31:0] st_data = 32'd0;
  bit          prev_mreq = 1'b0;
  bit          act [3];
  int          wait_cyc [3];
  bit          stop_new = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name, input int val);
    checks++;
    errors++;
    $display("FAIL %s: value %0d (t=%0t)", name, val, $time);
  endtask

  // One clock of stimulus: model/scoreboard push, interpreter stub, requesters.
  task automatic step();
    @(posedge clk); #1;
    if ((m_ren || m_wen) && !prev_mreq) begin
      bit [2:0] rq;
      int w, wi;
      bit to;
      iss_t is;
      rsp_t rs;
      rq = req_ren | req_wen;
      w = 3;
      if (DMA_PRIO != 0 && rq[2]) w = 2;
      else for (int k = 2; k >= 0; k--) if (rq[(mdl_rr + k) % 3]) w = (mdl_rr + k) % 3;
      if (w != 3) mdl_rr = (w + 1) % 3;
      wi = (w == 3) ? 0 : w;
      to = ($urandom_range(0, 9) == 0);
      st_delay = to ? 1000 : int'($urandom_range(0, 5));
      st_data = $urandom;
      is.idx = w;
      is.rd = req_ren[wi];
      is.addr = req_addr[32*wi +: 32];
      is.wdata = req_wdata[32*wi +: 32];
      is.len = to ? TIMEOUT : st_delay + 1;
      if (to) begin
        mdl_rdata = 32'd0;
        if (mdl_tocnt < 255) mdl_tocnt++;
      end else if (is.rd) begin
        mdl_rdata = st_data;
      end
      rs.idx = w;
      rs.rdata = mdl_rdata;
      rs.err = to;
      rs.tocnt = mdl_tocnt;
      iss_q.push_back(is);
      rsp_q.push_back(rs);
    end
    prev_mreq = m_ren || m_wen;
    // interpreter stub: ack after st_delay cycles, hold until strobes drop
    if (m_ren || m_wen) begin
      if (!m_ack) begin
        if (st_delay == 0) begin m_ack = 1'b1; m_data_o = st_data; end
        else begin st_delay--; m_data_o = $urandom; end
      end
      st_drop = $urandom_range(0, 2);
    end else if (m_ack) begin
      if (st_drop == 0) begin m_ack = 1'b0; m_data_o = $urandom; end
      else st_drop--;
    end else begin
      m_data_o = $urandom;
    end
    // requesters
    for (int i = 0; i < 3; i++) begin
      if (act[i]) begin
        wait_cyc[i]++;
        if (req_ack[i] || (grant == 2'(i) && $urandom_range(0, 19) == 0)) begin
          act[i] = 1'b0; req_ren[i] = 1'b0; req_wen[i] = 1'b0; wait_cyc[i] = 0;
        end else if (grant == 2'(i)) begin
          req_addr[32*i +: 32] = $urandom;
          req_wdata[32*i +: 32] = $urandom;
        end
        if (wait_cyc[i] > 300) begin
          fail_evt($sformatf("req%0d_starved", i), wait_cyc[i]);
          act[i] = 1'b0; req_ren[i] = 1'b0; req_wen[i] = 1'b0; wait_cyc[i] = 0;
        end
      end else if (!stop_new && grant != 2'(i) && !req_ack[i] && $urandom_range(0, 3) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        act[i] = 1'b1;
        wait_cyc[i] = 0;
        req_ren[i] = (op != 1);
        req_wen[i] = (op != 0);
        req_addr[32*i +: 32] = $urandom;
        req_wdata[32*i +: 32] = $urandom;
      end
    end
  endtask

  // Downstream monitor: each new issue against the model, then hold and length.
  iss_t       cur;
  int         cur_len = 0;
  bit         mon_mreq = 1'b0;
  logic [1:0] mon_prev_grant = 2'd3;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_mreq = 1'b0; mon_prev_grant = 2'd3; cur_len = 0;
    end else begin
      if (m_ren || m_wen) begin
        if (!mon_mreq) begin
          chk("idle_gap_grant", 32'(mon_prev_grant), 32'd3);
          if (iss_q.size() == 0) fail_evt("unexpected_issue", 0);
          else begin
            cur = iss_q.pop_front();
            chk("issue_grant", 32'(grant), 32'(cur.idx));
            chk("issue_m_ren", 32'(m_ren), 32'(cur.rd));
            chk("issue_m_wen", 32'(m_wen), 32'(!cur.rd));
          end
          cur_len = 0;
        end
        cur_len++;
        chk("m_addr", m_addr, cur.addr);
        chk("m_data_i", m_data_i, cur.wdata);
      end else if (mon_mreq) begin
        chk("issue_len", 32'(cur_len), 32'(cur.len));
      end
      mon_mreq = m_ren || m_wen;
      mon_prev_grant = grant;
    end
  end

  // Upstream monitor: each rising ack against the expected response.
  logic [2:0] prev_ack = 3'd0;
  rsp_t       r;
  always @(negedge clk) begin
    if (!rst_n) prev_ack = 3'd0;
    else begin
      if (req_ack != 3'd0 && prev_ack == 3'd0) begin
        if (rsp_q.size() == 0) fail_evt("unexpected_ack", int'(req_ack));
        else begin
          r = rsp_q.pop_front();
          chk("ack_onehot", 32'(req_ack), 32'(1) << r.idx);
          chk("rdata", req_rdata, r.rdata);
          chk("err", 32'(req_err), r.err ? (32'(1) << r.idx) : 32'd0);
          chk("timeout_cnt", 32'(timeout_cnt), 32'(r.tocnt));
        end
      end
      prev_ack = req_ack;
    end
  end

  initial begin
    req_ren = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    m_ack = 1'b0; m_data_o = '0;
    for (int i = 0; i < 3; i++) begin act[i] = 1'b0; wait_cyc[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_req_err", 32'(req_err), 32'd0);
    chk("rst_req_rdata", req_rdata, 32'd0);
    chk("rst_m_ren", 32'(m_ren), 32'd0);
    chk("rst_m_wen", 32'(m_wen), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_data_i", m_data_i, 32'd0);
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    rst_n = 1'b1;

    // a stray ack with nobody requesting must not start anything
    m_ack = 1'b1; m_data_o = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    chk("stale_ack_m_ren", 32'(m_ren), 32'd0);
    chk("stale_ack_grant", 32'(grant), 32'd3);
    chk("stale_ack_req_ack", 32'(req_ack), 32'd0);
    m_ack = 1'b0;
    @(negedge clk);

    // seed a read from requester 1 and a write from requester 0
    act[1] = 1'b1; req_ren[1] = 1'b1; req_addr[63:32] = 32'h1FC0_0010;
    act[0] = 1'b1; req_wen[0] = 1'b1; req_addr[31:0] = 32'h1F80_0004;
    req_wdata[31:0] = 32'h1234_5678;
    repeat (3000) step();

    // asynchronous reset in the middle of a downstream transaction
    begin
      int n;
      n = 0;
      while (!(m_ren || m_wen) && n < 200) begin step(); n++; end
      if (!(m_ren || m_wen)) fail_evt("no_issue_before_reset", n);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_m_ren", 32'(m_ren), 32'd0);
    chk("async_rst_m_wen", 32'(m_wen), 32'd0);
    chk("async_rst_grant", 32'(grant), 32'd3);
    chk("async_rst_req_ack", 32'(req_ack), 32'd0);
    chk("async_rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    iss_q.delete(); rsp_q.delete();
    mdl_rr = 0; mdl_rdata = 32'd0; mdl_tocnt = 0;
    prev_mreq = 1'b0; st_delay = 0; st_drop = 0; m_ack = 1'b0;
    // requesters 0 and 1 pending across reset: rr restarts at 0, so 0 wins
    req_ren = 3'b011; req_wen = 3'b000;
    act[0] = 1'b1; act[1] = 1'b1; act[2] = 1'b0;
    for (int i = 0; i < 3; i++) wait_cyc[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) step();

    // drain
    stop_new = 1'b1;
    begin
      int n;
      n = 0;
      while ((act[0] || act[1] || act[2] || grant != 2'd3 || m_ack) && n < 500) begin step(); n++; end
      if (n >= 500) fail_evt("drain_timeout", n);
    end
    repeat (3) @(negedge clk);
    chk("iss_q_drained", 32'(iss_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
